// File: rtl/seg_scan.sv
// seg_scan: converts three 6-bit unit counters to BCD and drives an 8-digit
// common-anode 7-segment panel by time-multiplexed scanning.
//
// Ports
//   clk    in   1  system clock
//   rst    in   1  synchronous reset, active-high
//   u_tot  in   6  total units remaining (digits 7..6)
//   u_cur  in   6  current-stage units remaining (digits 5..4)
//   u_wat  in   6  water level units (digits 3..2)
//   seg_n  out  8  active-low segments {dp,g,f,e,d,c,b,a}, dp always off
//   an_n   out  8  active-low anode enables, bit i selects digit i
//
// Parameter
//   SCA_CMAX  clk cycles each digit stays lit (>= 1)
//
// Configuration macro
//   SEG_SCAN_LZB_EN  when defined, a tens digit of 0 is stored as blank
//                    (leading-zero blanking); the ones digit always shows.
//
// Digits 1..0 are never written and stay blank.

module seg_scan #(
  parameter int SCA_CMAX = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] u_tot,
  input  logic [5:0] u_cur,
  input  logic [5:0] u_wat,
  output logic [7:0] seg_n,
  output logic [7:0] an_n
);

  localparam int             CW       = $clog2(SCA_CMAX + 1);
  localparam logic [CW-1:0]  DIV_LAST = CW'(SCA_CMAX - 1);
  localparam logic [3:0]     BLANK    = 4'hF;

  typedef enum logic [1:0] {
    LOAD,
    SHIFT,
    STORE
  } conv_state_e;

  conv_state_e state_q, state_d;
  logic [1:0]  chan_q, chan_d;
  logic [2:0]  step_q, step_d;
  logic [5:0]  bin_q, bin_d;
  logic [7:0]  bcd_q, bcd_d;
  logic [3:0]  digit_q [8];
  logic [3:0]  digit_d [8];
  logic [CW-1:0] div_q, div_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  seg_n_q, seg_n_d;
  logic [7:0]  an_n_q, an_n_d;

  logic [7:0]  bcd_adj;
  logic [3:0]  tens;

  // Active-low segment pattern for one digit code; anything that is not a
  // decimal digit (including BLANK) turns all segments off.
  function automatic logic [7:0] seg_pattern(input logic [3:0] d);
    logic [7:0] p;
    case (d)
      4'd0:    p = 8'hC0;
      4'd1:    p = 8'hF9;
      4'd2:    p = 8'hA4;
      4'd3:    p = 8'hB0;
      4'd4:    p = 8'h99;
      4'd5:    p = 8'h92;
      4'd6:    p = 8'h82;
      4'd7:    p = 8'hF8;
      4'd8:    p = 8'h80;
      4'd9:    p = 8'h90;
      default: p = 8'hFF;
    endcase
    return p;
  endfunction

  // Converter: one channel per LOAD/SHIFTx6/STORE pass. The binary value is
  // snapshotted in LOAD so input changes mid-conversion cannot mix digits.
  always_comb begin
    state_d = state_q;
    chan_d  = chan_q;
    step_d  = step_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    digit_d = digit_q;
    bcd_adj = bcd_q;
    tens    = bcd_q[7:4];

    case (state_q)
      LOAD: begin
        case (chan_q)
          2'd0:    bin_d = u_tot;
          2'd1:    bin_d = u_cur;
          default: bin_d = u_wat;
        endcase
        bcd_d   = 8'h00;
        step_d  = 3'd0;
        state_d = SHIFT;
      end

      SHIFT: begin
        // Double-dabble: correct each nibble before the shift so that a
        // nibble >= 5 carries into the next decade once doubled.
        if (bcd_q[3:0] >= 4'd5) bcd_adj[3:0] = bcd_q[3:0] + 4'd3;
        if (bcd_q[7:4] >= 4'd5) bcd_adj[7:4] = bcd_q[7:4] + 4'd3;
        {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
        step_d = step_q + 3'd1;
        if (step_q == 3'd5) state_d = STORE;
      end

      STORE: begin
`ifdef SEG_SCAN_LZB_EN
        if (bcd_q[7:4] == 4'd0) tens = BLANK;
`endif
        case (chan_q)
          2'd0: begin
            digit_d[7] = tens;
            digit_d[6] = bcd_q[3:0];
          end
          2'd1: begin
            digit_d[5] = tens;
            digit_d[4] = bcd_q[3:0];
          end
          default: begin
            digit_d[3] = tens;
            digit_d[2] = bcd_q[3:0];
          end
        endcase
        chan_d  = (chan_q == 2'd2) ? 2'd0 : chan_q + 2'd1;
        state_d = LOAD;
      end

      default: state_d = LOAD;
    endcase
  end

  // Scan divider and registered panel outputs. The outputs reflect the
  // index held before this edge, so an_n lags idx by one cycle.
  always_comb begin
    div_d = div_q + 1'b1;
    idx_d = idx_q;
    if (div_q == DIV_LAST) begin
      div_d = '0;
      idx_d = idx_q + 3'd1;
    end
    an_n_d  = ~(8'b1 << idx_q);
    seg_n_d = seg_pattern(digit_q[idx_q]);
  end

  // State registers; reset discards any partial conversion and blanks the panel.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LOAD;
      chan_q  <= 2'd0;
      step_q  <= 3'd0;
      bin_q   <= 6'd0;
      bcd_q   <= 8'h00;
      for (int i = 0; i < 8; i++) digit_q[i] <= BLANK;
      div_q   <= '0;
      idx_q   <= 3'd0;
      seg_n_q <= 8'hFF;
      an_n_q  <= 8'hFF;
    end else begin
      state_q <= state_d;
      chan_q  <= chan_d;
      step_q  <= step_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      digit_q <= digit_d;
      div_q   <= div_d;
      idx_q   <= idx_d;
      seg_n_q <= seg_n_d;
      an_n_q  <= an_n_d;
    end
  end

  assign seg_n = seg_n_q;
  assign an_n  = an_n_q;

endmodule
